// File: rtl/test_module.sv
// -----------------------------------------------------------------------------
// test_module
//
// Registered 1-bit adder used as a smoke-test / bring-up block for clock,
// reset and waveform-dump infrastructure. The two single-bit addends pass
// through an optional synchronizer, an optional glitch filter and a pipeline
// of configurable depth. c_o = {carry, sum} = {a & b, a ^ b}.
//
// Parameters:
//   SYNC_STAGES  0..3  flops on each input ahead of the adder (2 for async inputs)
//   PIPE_STAGES  1..4  register stages from the adder output to c_o
//
// Optional feature (compile-time macro TEST_MODULE_GLITCH_FILTER_EN):
//   When defined, a 2-sample agreement filter sits after the synchronizer on
//   each input. The filtered bit only takes a new value once two consecutive
//   samples agree, so single-cycle pulses are suppressed. This adds exactly one
//   cycle of latency. When undefined, no filter exists and pulses pass through.
//
// Latency from a sampling edge to c_o:
//   SYNC_STAGES + PIPE_STAGES (+1 with the filter) rising edges.
//
// Ports:
//   clk_i   in   1  system clock, rising edge
//   rst_ni  in   1  asynchronous active-low reset (released synchronously)
//   a_i     in   1  addend A
//   b_i     in   1  addend B
//   c_o     out  2  registered result, c_o[1] = carry, c_o[0] = sum
// -----------------------------------------------------------------------------
module test_module #(
  parameter int SYNC_STAGES = 0,
  parameter int PIPE_STAGES = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       a_i,
  input  logic       b_i,
  output logic [1:0] c_o
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("test_module: SYNC_STAGES=%0d outside legal range 0..3", SYNC_STAGES);
  end

  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_pipe
    $error("test_module: PIPE_STAGES=%0d outside legal range 1..4", PIPE_STAGES);
  end

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // Both inputs travel together as {a, b}, but each bit is an independent
  // synchronizer chain: a simultaneous async change of a and b may resolve on
  // different edges and show one intermediate result, which is acceptable.
  // ---------------------------------------------------------------------------
  logic [1:0] in_sync;

  if (SYNC_STAGES == 0) begin : g_no_sync
    // Inputs must meet setup/hold to clk_i in this configuration.
    assign in_sync = {a_i, b_i};
  end else begin : g_sync
    logic [1:0] sync_q [SYNC_STAGES];
    logic [1:0] sync_d [SYNC_STAGES];

    always_comb begin
      sync_d[0] = {a_i, b_i};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_d[i] = sync_q[i-1];
      end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // stage samples the value its predecessor held before this edge; blocking
    // assignments here would collapse the chain into a single flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        // NOTE: this flop array is reset element by element because the
        // whole datapath must read 0 during reset; an array without a reset
        // would map to RAM but would leak stale data after reset.
        for (int i = 0; i < SYNC_STAGES; i++) begin
          sync_q[i] <= '0;
        end
      end else begin
        sync_q <= sync_d;
      end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];
  end

  // ---------------------------------------------------------------------------
  // Optional 2-sample agreement filter
  // prev_q holds the previous synchronized sample. When the current sample
  // agrees with it, the filter passes the current sample straight into the
  // adder; otherwise it repeats the last accepted value (held_q). Using the
  // current sample on agreement is what keeps the added latency to one cycle.
  // ---------------------------------------------------------------------------
  logic [1:0] in_filt;

`ifdef TEST_MODULE_GLITCH_FILTER_EN
  logic [1:0] prev_q;
  logic [1:0] prev_d;
  logic [1:0] held_q;
  logic [1:0] held_d;
  logic [1:0] agree;

  // NOTE: every signal written in this block gets a value on every path, so
  // no latch is inferred.
  always_comb begin
    agree   = ~(in_sync ^ prev_q);
    in_filt = (agree & in_sync) | (~agree & held_q);
    prev_d  = in_sync;
    held_d  = in_filt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
      held_q <= '0;
    end else begin
      prev_q <= prev_d;
      held_q <= held_d;
    end
  end
`else
  assign in_filt = in_sync;
`endif

  // ---------------------------------------------------------------------------
  // Adder: zero-extended 1-bit operands, so the 2-bit result can never be 11.
  // ---------------------------------------------------------------------------
  logic [1:0] sum;

  always_comb begin
    sum = {1'b0, in_filt[1]} + {1'b0, in_filt[0]};
  end

  // ---------------------------------------------------------------------------
  // Output pipeline: free-running, no enable. Stage 0 registers the adder, so
  // there is never a combinational path from an input to c_o.
  // ---------------------------------------------------------------------------
  logic [1:0] pipe_q [PIPE_STAGES];
  logic [1:0] pipe_d [PIPE_STAGES];

  always_comb begin
    pipe_d[0] = sum;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign c_o = pipe_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_test_module.sv
// -----------------------------------------------------------------------------
// tb_test_module
//
// Directed bench for test_module. Two instances share the stimulus:
//   u_dut_def   default parameters (SYNC_STAGES=0, PIPE_STAGES=1)
//   u_dut_deep  SYNC_STAGES=2, PIPE_STAGES=3
// Inputs are driven and outputs sampled on the falling edge of a 100 MHz
// clock, so each rising edge samples the value set on the preceding falling
// edge. Expectations follow the build: with TEST_MODULE_GLITCH_FILTER_EN
// defined, latencies grow by one and single-cycle pulses are suppressed.
// -----------------------------------------------------------------------------
module tb_test_module;

`ifdef TEST_MODULE_GLITCH_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif
  localparam int L_DEF  = 1 + FILT;
  localparam int L_DEEP = 2 + 3 + FILT;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       b;
  logic [1:0] c_def;
  logic [1:0] c_deep;

  int n_cmp = 0;
  int n_bad = 0;

  test_module u_dut_def (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .a_i    (a),
    .b_i    (b),
    .c_o    (c_def)
  );

  test_module #(
    .SYNC_STAGES (2),
    .PIPE_STAGES (3)
  ) u_dut_deep (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .a_i    (a),
    .b_i    (b),
    .c_o    (c_deep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden history for the random test: hist[k] is the {a,b} sample taken k
  // edges ago; edges during reset record 00 because every flop is cleared.
  logic [1:0] hist [16];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) hist[i] <= 2'b00;
    end else begin
      for (int i = 15; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= {a, b};
    end
  end

  function automatic logic [1:0] golden(input logic [1:0] ab);
    return {ab[1] & ab[0], ab[1] ^ ab[0]};
  endfunction

  // One rising edge, landing on the following falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic flush();
    a = 1'b0;
    b = 1'b0;
    repeat (L_DEEP + 2) cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    a     = 1'b1;
    b     = 1'b1;
    repeat (3) cycle();
    n_cmp++;
    if (c_def !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_def: c_o=%b expected 00", c_def);
    end
    n_cmp++;
    if (c_deep !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_deep: c_o=%b expected 00", c_deep);
    end
  endtask

  // a=b=0 held for 10 cycles after release: c_o stays 00 throughout.
  task automatic test_idle();
    a     = 1'b0;
    b     = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_cmp++;
      if (c_def !== 2'b00) begin
        n_bad++;
        $display("FAIL idle[%0d]: c_o=%b expected 00", i, c_def);
      end
    end
  endtask

  // Truth table 01,10,11,00 -> 01,01,10,00. With the filter each vector is
  // held two cycles; the first of those still shows the previous result.
  task automatic test_sequence();
    logic [1:0] vec [4];
    logic [1:0] exp [4];
    logic [1:0] prev;
    vec  = '{2'b01, 2'b10, 2'b11, 2'b00};
    exp  = '{2'b01, 2'b01, 2'b10, 2'b00};
    prev = 2'b00;
    for (int i = 0; i < 4; i++) begin
      {a, b} = vec[i];
      for (int h = 0; h <= FILT; h++) begin
        cycle();
        n_cmp++;
        if (h == FILT) begin
          if (c_def !== exp[i]) begin
            n_bad++;
            $display("FAIL seq[%0d]: ab=%b c_o=%b expected %b", i, vec[i], c_def, exp[i]);
          end
        end else begin
          if (c_def !== prev) begin
            n_bad++;
            $display("FAIL seq_hold[%0d]: ab=%b c_o=%b expected %b", i, vec[i], c_def, prev);
          end
        end
      end
      prev = exp[i];
    end
  endtask

  // Reset dropped mid-cycle while c_o=10 clears immediately; after release
  // the result returns L_DEF edges later.
  task automatic test_async_reset();
    a = 1'b1;
    b = 1'b1;
    repeat (L_DEEP + 1) cycle();
    n_cmp++;
    if (c_def !== 2'b10) begin
      n_bad++;
      $display("FAIL areset_pre: c_o=%b expected 10", c_def);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (c_def !== 2'b00) begin
      n_bad++;
      $display("FAIL areset_now_def: c_o=%b expected 00", c_def);
    end
    n_cmp++;
    if (c_deep !== 2'b00) begin
      n_bad++;
      $display("FAIL areset_now_deep: c_o=%b expected 00", c_deep);
    end
    repeat (2) cycle();
    n_cmp++;
    if (c_def !== 2'b00) begin
      n_bad++;
      $display("FAIL areset_held: c_o=%b expected 00", c_def);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_cmp++;
    if (c_def !== 2'b00) begin
      n_bad++;
      $display("FAIL areset_release: c_o=%b expected 00", c_def);
    end
    @(negedge clk);
    for (int e = 1; e <= L_DEF; e++) begin
      cycle();
      n_cmp++;
      if (e < L_DEF) begin
        if (c_def !== 2'b00) begin
          n_bad++;
          $display("FAIL areset_refill[%0d]: c_o=%b expected 00", e, c_def);
        end
      end else begin
        if (c_def !== 2'b10) begin
          n_bad++;
          $display("FAIL areset_return: c_o=%b expected 10", c_def);
        end
      end
    end
  endtask

  // Step a=b=1 into the deep instance: 00 for L_DEEP-1 edges, then 10.
  task automatic test_deep_latency();
    flush();
    a = 1'b1;
    b = 1'b1;
    for (int e = 1; e <= L_DEEP + 1; e++) begin
      cycle();
      n_cmp++;
      if (e < L_DEEP) begin
        if (c_deep !== 2'b00) begin
          n_bad++;
          $display("FAIL deep_lat[%0d]: c_o=%b expected 00", e, c_deep);
        end
      end else begin
        if (c_deep !== 2'b10) begin
          n_bad++;
          $display("FAIL deep_lat[%0d]: c_o=%b expected 10", e, c_deep);
        end
      end
    end
  endtask

  // Single-cycle pulse a=1,b=0, then the same value held three cycles.
  task automatic test_glitch();
    logic [1:0] exp_pulse;
    flush();
    exp_pulse = (FILT != 0) ? 2'b00 : 2'b01;
    a = 1'b1;
    b = 1'b0;
    cycle();
    a = 1'b0;
    n_cmp++;
    if (c_def !== exp_pulse) begin
      n_bad++;
      $display("FAIL pulse: c_o=%b expected %b", c_def, exp_pulse);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (c_def !== 2'b00) begin
        n_bad++;
        $display("FAIL pulse_after[%0d]: c_o=%b expected 00", i, c_def);
      end
    end
    a = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      cycle();
      n_cmp++;
      if (e < L_DEF) begin
        if (c_def !== 2'b00) begin
          n_bad++;
          $display("FAIL held[%0d]: c_o=%b expected 00", e, c_def);
        end
      end else begin
        if (c_def !== 2'b01) begin
          n_bad++;
          $display("FAIL held[%0d]: c_o=%b expected 01", e, c_def);
        end
      end
    end
    a = 1'b0;
    flush();
  endtask

  // 1000 random cycles against the delayed golden model. With the filter,
  // each value is held two cycles so the filter never has to suppress one.
  task automatic test_random();
    logic [1:0] exp_def;
    logic [1:0] exp_deep;
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (i % (1 + FILT) == 0) begin
        {a, b} = 2'($urandom_range(0, 3));
      end
      cycle();
      exp_def  = golden(hist[L_DEF-1]);
      exp_deep = golden(hist[L_DEEP-1]);
      n_cmp++;
      if (c_def !== exp_def) begin
        n_bad++;
        $display("FAIL rand_def[%0d]: c_o=%b expected %b", i, c_def, exp_def);
      end
      n_cmp++;
      if (c_deep !== exp_deep) begin
        n_bad++;
        $display("FAIL rand_deep[%0d]: c_o=%b expected %b", i, c_deep, exp_deep);
      end
      n_cmp++;
      if (c_def === 2'b11 || c_deep === 2'b11) begin
        n_bad++;
        $display("FAIL rand_11[%0d]: c_def=%b c_deep=%b expected neither 11", i, c_def, c_deep);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a     = 1'b0;
    b     = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle();
    test_sequence();
    test_async_reset();
    test_deep_latency();
    test_glitch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
